// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 panel-side receiver.
package hub75_pkg;

  localparam int COLS_DEF = 64;
  localparam int ROWS_DEF = 16;

  localparam int PIX_R = 2;
  localparam int PIX_G = 1;
  localparam int PIX_B = 0;

  localparam int CNT_W = 7;

  // Synchronized data vector layout: {D,C,B,A, R0,G0,B0, R1,G1,B1, OE}
  localparam int BUS_W    = 11;
  localparam int BUS_OE   = 0;
  localparam int BUS_BOT  = 1;
  localparam int BUS_TOP  = 4;
  localparam int BUS_ADDR = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_t;

  function automatic int bmp_w(input int cols);
    return 3 * cols;
  endfunction

endpackage

// File: rtl/hub75_in_sync.sv
// Multi-flop synchronizer for the bus data plus the two strobes, with
// registered rising-edge pulses kept aligned to the data they qualify.
module hub75_in_sync #(
  parameter int N      = 11,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data,
  input  logic [1:0]   strobe,
  output logic [N-1:0] data_q,
  output logic [1:0]   rise
);

  logic [N+1:0] stg [STAGES];
  logic [1:0]   strobe_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      strobe_prev <= '0;
      data_q      <= '0;
      rise        <= '0;
    end else begin
      stg[0] <= {strobe, data};
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      // edge detect stage: data is registered with its pulse so both stay aligned
      strobe_prev <= stg[STAGES-1][N+1:N];
      data_q      <= stg[STAGES-1][N-1:0];
      rise        <= stg[STAGES-1][N+1:N] & ~strobe_prev;
    end
  end

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: shifts in one scan row for both halves and
// publishes it on each LAT rise together with protocol-check flags.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COLS        = COLS_DEF,
  parameter int ROWS        = ROWS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     A,
  input  logic                     B,
  input  logic                     C,
  input  logic                     D,
  input  logic                     R0,
  input  logic                     G0,
  input  logic                     B0,
  input  logic                     R1,
  input  logic                     G1,
  input  logic                     B1,
  input  logic                     SCLK,
  input  logic                     LAT,
  input  logic                     OE,
  output logic                     row_valid,
  output logic [3:0]               row_addr,
  output logic [bmp_w(COLS)-1:0]   row_top,
  output logic [bmp_w(COLS)-1:0]   row_bot,
  output logic                     len_err,
  output logic                     seq_err,
  output logic                     blank_err,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt
);

  localparam int                BW       = bmp_w(COLS);
  localparam logic [3:0]        LAST_ROW = 4'(ROWS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ROW  = CNT_W'(COLS);

  logic [BUS_W-1:0] bus_raw;
  logic [BUS_W-1:0] bus_q;
  logic [1:0]       rise;
  logic             sclk_rise;
  logic             lat_rise;

  assign bus_raw = {D, C, B, A, R0, G0, B0, R1, G1, B1, OE};

  hub75_in_sync #(
    .N      (BUS_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .data   (bus_raw),
    .strobe ({SCLK, LAT}),
    .data_q (bus_q),
    .rise   (rise)
  );

  assign sclk_rise = rise[1];
  assign lat_rise  = rise[0];

  logic [2:0] top_pix;
  logic [2:0] bot_pix;
  logic [3:0] addr_in;
  logic       oe_q;

  assign top_pix = bus_q[BUS_TOP +: 3];
  assign bot_pix = bus_q[BUS_BOT +: 3];
  assign addr_in = bus_q[BUS_ADDR +: 4];
  assign oe_q    = bus_q[BUS_OE];

  rx_state_t state_q;
  rx_state_t state_d;
  logic      have_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (lat_rise) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    have_prev = 1'b0;
    if (state_q == ST_RUN) have_prev = 1'b1;
  end

  logic [BW-1:0]    top_sr;
  logic [BW-1:0]    bot_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       prev_addr;

  logic [BW-1:0]    top_shift;
  logic [BW-1:0]    bot_shift;
  logic [BW-1:0]    top_row;
  logic [BW-1:0]    bot_row;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_row;
  logic [3:0]       next_addr;

  // A shift coinciding with a latch lands in the row being published.
  always_comb begin
    top_shift = {top_sr[BW-4:0], top_pix};
    bot_shift = {bot_sr[BW-4:0], bot_pix};
    cnt_inc   = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;
    top_row   = sclk_rise ? top_shift : top_sr;
    bot_row   = sclk_rise ? bot_shift : bot_sr;
    cnt_row   = sclk_rise ? cnt_inc : bit_cnt;
    next_addr = (prev_addr == LAST_ROW) ? 4'd0 : prev_addr + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_sr    <= '0;
      bot_sr    <= '0;
      bit_cnt   <= '0;
      prev_addr <= '0;
    end else begin
      if (sclk_rise) begin
        top_sr <= top_shift;
        bot_sr <= bot_shift;
      end
      if (lat_rise)       bit_cnt <= '0;
      else if (sclk_rise) bit_cnt <= cnt_inc;
      if (lat_rise)       prev_addr <= addr_in;
    end
  end

  // publish stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_valid  <= 1'b0;
      len_err    <= 1'b0;
      seq_err    <= 1'b0;
      blank_err  <= 1'b0;
      frame_done <= 1'b0;
      row_addr   <= '0;
      row_top    <= '0;
      row_bot    <= '0;
      frame_cnt  <= '0;
    end else begin
      row_valid  <= lat_rise;
      len_err    <= lat_rise && (cnt_row != CNT_ROW);
      seq_err    <= lat_rise && have_prev && (addr_in != next_addr);
      blank_err  <= lat_rise && !oe_q;
      frame_done <= lat_rise && (addr_in == LAST_ROW);
      if (lat_rise) begin
        row_addr <= addr_in;
        row_top  <= top_row;
        row_bot  <= bot_row;
        if (addr_in == LAST_ROW) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed, table-driven bench for hub75_rx with hand sequences for reset and
// coincident SCLK/LAT corner cases.
module tb_hub75_rx;
  import hub75_pkg::*;

  localparam int COLS = 64;
  localparam int BW   = 3 * COLS;
  localparam int NV   = 39;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic A = 0, B = 0, C = 0, D = 0;
  logic R0 = 0, G0 = 0, B0 = 0, R1 = 0, G1 = 0, B1 = 0;
  logic SCLK = 0, LAT = 0, OE = 1;

  logic          row_valid;
  logic [3:0]    row_addr;
  logic [BW-1:0] row_top;
  logic [BW-1:0] row_bot;
  logic          len_err, seq_err, blank_err, frame_done;
  logic [15:0]   frame_cnt;

  hub75_rx #(.COLS(COLS), .ROWS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .SCLK(SCLK), .LAT(LAT), .OE(OE),
    .row_valid(row_valid), .row_addr(row_addr),
    .row_top(row_top), .row_bot(row_bot),
    .len_err(len_err), .seq_err(seq_err), .blank_err(blank_err),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int   rv_cnt = 0;
  logic cap_len, cap_seq, cap_blank, cap_frame;
  logic flag_leak = 1'b0;

  always @(negedge clk) begin
    if (row_valid) begin
      rv_cnt++;
      cap_len   = len_err;
      cap_seq   = seq_err;
      cap_blank = blank_err;
      cap_frame = frame_done;
    end else if (len_err || seq_err || blank_err || frame_done) begin
      flag_leak = 1'b1;
    end
  end

  typedef struct {
    int         n;
    logic [3:0] addr;
    logic       oe;
    logic       len, seq, blank, frame;
    logic [15:0] fcnt;
    int         seed;
    logic [2:0] bx;
  } vec_t;

  vec_t vt [NV];

  logic [BW-1:0] exp_top = '0;
  logic [BW-1:0] exp_bot = '0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] pix(input int seed, input int i);
    return 3'((i + seed) % 8);
  endfunction

  // Expected bitmap: each new pixel enters at column 0, older ones move up.
  task automatic model_push(input logic [2:0] t, input logic [2:0] b);
    exp_top = {exp_top[BW-4:0], t};
    exp_bot = {exp_bot[BW-4:0], b};
  endtask

  task automatic shift_px(input logic [2:0] t, input logic [2:0] b);
    @(negedge clk);
    {R0, G0, B0} = t;
    {R1, G1, B1} = b;
    @(negedge clk);
    SCLK = 1'b1;
    repeat (2) @(negedge clk);
    SCLK = 1'b0;
  endtask

  task automatic shift_row(input int n, input int seed, input logic [2:0] bx);
    for (int i = 0; i < n; i++) begin
      shift_px(pix(seed, i), pix(seed, i) ^ bx);
      model_push(pix(seed, i), pix(seed, i) ^ bx);
    end
  endtask

  // Drive a LAT pulse (optionally with a coincident SCLK rise) and confirm
  // exactly one row_valid within a fixed window.
  task automatic latch(input string nm, input logic [3:0] addr, input logic oe,
                       input logic with_sclk, input logic [2:0] t, input logic [2:0] b);
    int start;
    @(negedge clk);
    {D, C, B, A} = addr;
    OE = oe;
    if (with_sclk) begin
      {R0, G0, B0} = t;
      {R1, G1, B1} = b;
    end
    start = rv_cnt;
    @(negedge clk);
    LAT = 1'b1;
    if (with_sclk) SCLK = 1'b1;
    repeat (2) @(negedge clk);
    LAT  = 1'b0;
    SCLK = 1'b0;
    repeat (8) @(negedge clk);
    check({nm, " row_valid count"}, 256'(rv_cnt - start), 256'(1));
  endtask

  task automatic check_row(input string nm, input logic [3:0] addr, input logic len,
                           input logic seq, input logic blank, input logic frame,
                           input logic [15:0] fcnt);
    check({nm, " addr"},  256'(row_addr),  256'(addr));
    check({nm, " len"},   256'(cap_len),   256'(len));
    check({nm, " seq"},   256'(cap_seq),   256'(seq));
    check({nm, " blank"}, 256'(cap_blank), 256'(blank));
    check({nm, " frame"}, 256'(cap_frame), 256'(frame));
    check({nm, " fcnt"},  256'(frame_cnt), 256'(fcnt));
    check({nm, " top"},   256'(row_top),   256'(exp_top));
    check({nm, " bot"},   256'(row_bot),   256'(exp_bot));
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      vt[k].n     = COLS;
      vt[k].addr  = 4'(k % 16);
      vt[k].oe    = 1'b1;
      vt[k].len   = 1'b0;
      vt[k].seq   = 1'b0;
      vt[k].blank = 1'b0;
      vt[k].frame = ((k % 16) == 15);
      vt[k].fcnt  = (k < 15) ? 16'd0 : (k < 31) ? 16'd1 : 16'd2;
      vt[k].seed  = k;
      vt[k].bx    = (k == 0) ? 3'b000 : 3'b101;
    end
    //           n   addr  oe  len seq blk frm fcnt  seed bx
    vt[32] = '{ 64, 4'd3,  1, 0,  1,  0,  0,  16'd2, 32, 3'b011};
    vt[33] = '{ 64, 4'd5,  1, 0,  1,  0,  0,  16'd2, 33, 3'b110};
    vt[34] = '{ 63, 4'd6,  1, 1,  0,  0,  0,  16'd2, 34, 3'b001};
    vt[35] = '{ 65, 4'd7,  1, 1,  0,  0,  0,  16'd2, 35, 3'b010};
    vt[36] = '{ 64, 4'd8,  0, 0,  0,  1,  0,  16'd2, 36, 3'b100};
    vt[37] = '{  0, 4'd9,  1, 1,  0,  0,  0,  16'd2, 37, 3'b000};
    vt[38] = '{ 64, 4'd10, 1, 0,  0,  0,  0,  16'd2, 38, 3'b111};

    repeat (3) @(negedge clk);
    check("reset row_valid", 256'(row_valid), 256'(0));
    check("reset row_addr",  256'(row_addr),  256'(0));
    check("reset row_top",   256'(row_top),   256'(0));
    check("reset frame_cnt", 256'(frame_cnt), 256'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < NV; k++) begin
      string nm;
      nm = $sformatf("v%0d", k);
      shift_row(vt[k].n, vt[k].seed, vt[k].bx);
      latch(nm, vt[k].addr, vt[k].oe, 1'b0, 3'b000, 3'b000);
      check_row(nm, vt[k].addr, vt[k].len, vt[k].seq, vt[k].blank, vt[k].frame, vt[k].fcnt);
      if (k == 0) begin
        check("v0 col63", 256'(row_top[3*63 +: 3]), 256'(3'b000));
        check("v0 col0",  256'(row_top[2:0]),       256'(3'b111));
      end
      if (vt[k].n == 65)
        check({nm, " col63 2nd pixel"}, 256'(row_top[3*63 +: 3]), 256'(pix(vt[k].seed, 1)));
    end

    // Coincident SCLK and LAT rise after 63 ordinary shifts
    shift_row(63, 50, 3'b011);
    model_push(pix(50, 63), pix(50, 63) ^ 3'b011);
    latch("same", 4'd11, 1'b1, 1'b1, pix(50, 63), pix(50, 63) ^ 3'b011);
    check_row("same", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    check("same col0", 256'(row_top[2:0]), 256'(pix(50, 63)));

    // Reset in the middle of a row discards it
    shift_row(30, 60, 3'b001);
    begin
      int start;
      start = rv_cnt;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("rst no row_valid", 256'(rv_cnt - start), 256'(0));
      check("rst row_addr",     256'(row_addr),       256'(0));
      check("rst row_top",      256'(row_top),        256'(0));
      check("rst frame_cnt",    256'(frame_cnt),      256'(0));
    end
    exp_top = '0;
    exp_bot = '0;
    shift_row(COLS, 70, 3'b110);
    latch("post", 4'd7, 1'b1, 1'b0, 3'b000, 3'b000);
    check_row("post", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    check("flags only with row_valid", 256'(flag_leak), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hub75_rx.md
# hub75_rx

Panel-side receiver for the HUB75 row-scan interface driven by the matrix driver (A–D, R0/G0/B0/R1/G1/B1, SCLK, LAT, OE). It oversamples the serial bus on the system clock, shifts in one scan row of pixel data for both panel halves, and publishes the completed row as two bitmaps on each LAT rising edge. It also checks protocol rules: shift length, row sequence, and blanking during latch. It serves as the loopback checker and frame-capture front end next to the driver.

## Interface
Parameters:
- COLS, 64, pixels per row per half; a bitmap is 3*COLS bits.
- ROWS, 16, scan rows addressed by {D,C,B,A}.
- SYNC_STAGES, 2, synchronizer depth on every bus input.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- A, B, C, D  in  1 each  row address; D is the MSB.
- R0, G0, B0  in  1 each  upper-half pixel bits.
- R1, G1, B1  in  1 each  lower-half pixel bits.
- SCLK  in  1  shift clock; data is sampled on its rising edge.
- LAT  in  1  latch; its rising edge ends a row.
- OE  in  1  output enable, active-low (0 = panel lit).
- row_valid  out  1  one-cycle pulse: row published.
- row_addr  out  4  address of the published row.
- row_top, row_bot  out  3*COLS  published bitmaps. Column c = bits [3c+2:3c] = {R,G,B}.
- len_err  out  1  qualified by row_valid: shift count was not COLS.
- seq_err  out  1  qualified by row_valid: row_addr is not the previous address +1 mod ROWS.
- blank_err  out  1  qualified by row_valid: OE was 0 at the LAT edge.
- frame_done  out  1  qualified by row_valid: row_addr == ROWS-1.
- frame_cnt  out  16  completed frames; wraps to 0.

## Operation
- All 11 bus inputs pass through SYNC_STAGES flops as one aligned vector. Rising edges of SCLK and LAT are detected from the last two synchronized samples.
- On an SCLK rise:
  - top_sr <= {top_sr[3*COLS-4:0], R0,G0,B0}, and likewise bot_sr with R1,G1,B1.
  - bit_cnt increments, saturating at 127 (7 bits).
  - The first pixel shifted in after a latch ends at column COLS-1.
- On a LAT rise:
  - row_top/row_bot <= shift registers; row_addr <= {D,C,B,A}.
  - len_err = (bit_cnt != COLS). bit_cnt clears; the shift registers are not cleared.
  - blank_err = synchronized OE == 0.
  - seq_err = have_prev && addr != prev+1 mod ROWS. have_prev then sets and prev <= addr.
  - If addr == ROWS-1: frame_done = 1 and frame_cnt increments.
- SCLK rise and LAT rise in the same cycle: shift first, then latch. The published row includes that bit, and bit_cnt for the row counts it.
- Two LAT rises with no SCLK between: the second publishes the same data with len_err = 1 (count 0).
- bit_cnt > COLS: only the last COLS pixels are kept; len_err = 1.
- The state machine has two states: IDLE (before the first LAT, have_prev = 0) and RUN. The block never stalls, and it does not backpressure the bus.

## Timing
- Reset values:
  - row_valid, len_err, seq_err, blank_err, frame_done = 0.
  - row_addr = 0; row_top, row_bot = 0; frame_cnt = 0.
  - bit_cnt = 0, have_prev = 0, synchronizers = 0.
- A reset assertion mid-row discards the partial row. No row_valid is produced for it.
- Latency: a pin edge reaches edge detection SYNC_STAGES+1 clk later. row_valid and all outputs are registered and update 1 cycle after that, i.e. SYNC_STAGES+2 clk after the LAT pin rises.
- Outputs hold their values until the next row_valid. The error and frame_done flags are valid only in the row_valid cycle and are 0 otherwise.
- Input requirements:
  - SCLK high and low each ≥ 2 clk periods.
  - Data stable from 1 clk before to 1 clk after the SCLK rise.
  - LAT high ≥ 2 clk periods.

## Structure
- Package hub75_pkg holds:
  - COLS_DEF, ROWS_DEF, and the pixel field offsets R=2, G=1, B=0.
  - bitmap width function 3*COLS.
  - the 7-bit bit_cnt width constant.
- Sub-module hub75_in_sync (N-bit synchronizer plus rise detect for SCLK and LAT) is instantiated once for the 11-bit bus vector. The remaining logic lives in hub75_rx.

## Test plan
- After reset: shift 64 pixels, pixel i = (i%8) on both halves; then LAT with addr 0, OE=1 → row_valid once, col 63 = 3'b000, col 0 = 3'b111, all error flags 0.
- Rows 0..15 in order, twice → frame_done on addr 15 both times; frame_cnt = 2; seq_err = 0 throughout.
- Row sequence 3, then 5 → the second row_valid has seq_err = 1. The first row after reset has seq_err = 0 even for addr 7.
- Rows of 63 and 65 shifts → len_err = 1 on each. For 65, col 63 holds the 2nd pixel shifted.
- LAT with OE=0 → blank_err = 1. SCLK rise and LAT rise in the same synchronized sample with 63 prior shifts → len_err = 0, last bit at col 0.
- Assert rst low after 30 shifts, release, then shift 64 and latch → exactly one row_valid, correct data, len_err = 0, frame_cnt = 0.
